// File: rtl/tx_frame_gen_if.sv
// tx_frame_gen_if: payload byte stream between the byte source and the framer.
interface tx_frame_gen_if;
    logic [7:0] data_tdata;
    logic       data_tvalid;
    logic       data_tready;

    modport master (output data_tdata, data_tvalid, input data_tready);
    modport slave  (input data_tdata, data_tvalid, output data_tready);
endinterface

// File: rtl/tx_frame_gen.sv
// tx_frame_gen: preamble + Barker sync + BPSK/QPSK payload symbol framer, paced by a symbol strobe.
module tx_frame_gen #(
    parameter int                    WIDTH       = 16,
    parameter int                    BARKER_LEN  = 13,
    parameter logic [BARKER_LEN-1:0] BARKER_CODE = 13'b1111100110101
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_sym_en,
    input  logic                    i_start,
    input  logic                    i_bpsk,
    input  logic [7:0]              i_pd_window,
    input  logic [7:0]              i_payload_len,
    input  logic [15:0]             i_amplitude,
    tx_frame_gen_if.slave           data_if,
    output logic signed [WIDTH-1:0] o_i_sym,
    output logic signed [WIDTH-1:0] o_q_sym,
    output logic                    o_sym_valid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_underrun
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_PRE, S_BARKER, S_PAYLOAD} state_t;
    typedef enum logic [2:0] {EM_NONE, EM_PRE, EM_CHIP, EM_FETCH, EM_SHIFT, EM_END} emit_t;

    state_t                 r_state, w_state;
    emit_t                  w_emit;
    logic                   r_bpsk, w_bpsk;
    logic [7:0]             r_win, w_win, r_len, w_len;
    logic [14:0]            r_amp, w_amp;
    logic [7:0]             r_pre_cnt, w_pre_cnt, r_byte_cnt, w_byte_cnt;
    logic [3:0]             r_chip_cnt, w_chip_cnt;
    logic [2:0]             r_bit_cnt, w_bit_cnt, w_last_bit;
    logic [7:0]             r_shift, w_shift, w_in_byte;
    logic signed [WIDTH-1:0] r_i, w_i, r_q, w_q, w_pos, w_neg;
    logic                   r_valid, w_valid, r_done, w_done, r_under, w_under;
    logic                   w_fetch;
    logic [BARKER_LEN-1:0]  w_code;

    assign w_pos      = WIDTH'({1'b0, r_amp});
    assign w_neg      = -w_pos;
    assign w_last_bit = r_bpsk ? 3'd7 : 3'd3;
    assign w_code     = BARKER_CODE << r_chip_cnt;
    assign w_in_byte  = data_if.data_tvalid ? data_if.data_tdata : 8'h00;
    // A byte is pulled on the strobe that starts the first symbol of each payload byte
    assign w_fetch = i_sym_en &&
                     ((r_state == S_BARKER && r_chip_cnt == 4'(BARKER_LEN) && r_len != 8'd0) ||
                      (r_state == S_PAYLOAD && r_bit_cnt == w_last_bit && r_byte_cnt != r_len - 8'd1));
    assign data_if.data_tready = w_fetch;

    always_comb begin
        w_state    = r_state;
        w_bpsk     = r_bpsk;
        w_win      = r_win;
        w_len      = r_len;
        w_amp      = r_amp;
        w_pre_cnt  = r_pre_cnt;
        w_chip_cnt = r_chip_cnt;
        w_byte_cnt = r_byte_cnt;
        w_bit_cnt  = r_bit_cnt;
        w_shift    = r_shift;
        w_i        = r_i;
        w_q        = r_q;
        w_valid    = r_valid;
        w_done     = 1'b0;
        w_under    = r_under;
        w_emit     = EM_NONE;
        unique case (r_state)
            S_IDLE: if (i_start && !r_done) begin
                w_state    = S_ARM;
                w_bpsk     = i_bpsk;
                w_win      = i_pd_window;
                w_len      = i_payload_len;
                w_amp      = i_amplitude[15] ? 15'h7FFF : i_amplitude[14:0];
                w_under    = 1'b0;
                w_pre_cnt  = '0;
                w_chip_cnt = '0;
                w_byte_cnt = '0;
                w_bit_cnt  = '0;
                w_shift    = '0;
            end
            S_ARM:     if (i_sym_en) w_emit = (r_win != 8'd0) ? EM_PRE : EM_CHIP;
            S_PRE:     if (i_sym_en) w_emit = (r_pre_cnt != r_win) ? EM_PRE : EM_CHIP;
            S_BARKER:  if (i_sym_en) w_emit = (r_chip_cnt != 4'(BARKER_LEN)) ? EM_CHIP :
                                              (r_len != 8'd0) ? EM_FETCH : EM_END;
            S_PAYLOAD: if (i_sym_en) w_emit = (r_bit_cnt != w_last_bit) ? EM_SHIFT :
                                              (r_byte_cnt != r_len - 8'd1) ? EM_FETCH : EM_END;
            default:   w_state = S_IDLE;
        endcase
        if (w_emit == EM_PRE) begin
            w_state   = S_PRE;
            w_pre_cnt = r_pre_cnt + 8'd1;
            w_i       = w_pos;
            w_q       = r_bpsk ? '0 : w_pos;
            w_valid   = 1'b1;
        end
        if (w_emit == EM_CHIP) begin
            w_state    = S_BARKER;
            w_chip_cnt = r_chip_cnt + 4'd1;
            w_i        = w_code[BARKER_LEN-1] ? w_pos : w_neg;
            w_q        = r_bpsk ? '0 : w_i;
            w_valid    = 1'b1;
        end
        if (w_emit == EM_FETCH) begin
            w_state    = S_PAYLOAD;
            w_byte_cnt = (r_state == S_PAYLOAD) ? r_byte_cnt + 8'd1 : 8'd0;
            w_bit_cnt  = '0;
            w_shift    = w_in_byte;
            w_under    = r_under | ~data_if.data_tvalid;
        end
        if (w_emit == EM_SHIFT) begin
            w_bit_cnt = r_bit_cnt + 3'd1;
            w_shift   = r_bpsk ? {r_shift[6:0], 1'b0} : {r_shift[5:0], 2'b00};
        end
        if (w_emit == EM_FETCH || w_emit == EM_SHIFT) begin
            w_i     = w_shift[7] ? w_pos : w_neg;
            w_q     = r_bpsk ? '0 : (w_shift[6] ? w_pos : w_neg);
            w_valid = 1'b1;
        end
        if (w_emit == EM_END) begin
            w_state = S_IDLE;
            w_i     = '0;
            w_q     = '0;
            w_valid = 1'b0;
            w_done  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bpsk     <= 1'b0;
            r_win      <= '0;
            r_len      <= '0;
            r_amp      <= '0;
            r_pre_cnt  <= '0;
            r_chip_cnt <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_i        <= '0;
            r_q        <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_under    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_bpsk     <= w_bpsk;
            r_win      <= w_win;
            r_len      <= w_len;
            r_amp      <= w_amp;
            r_pre_cnt  <= w_pre_cnt;
            r_chip_cnt <= w_chip_cnt;
            r_byte_cnt <= w_byte_cnt;
            r_bit_cnt  <= w_bit_cnt;
            r_shift    <= w_shift;
            r_i        <= w_i;
            r_q        <= w_q;
            r_valid    <= w_valid;
            r_done     <= w_done;
            r_under    <= w_under;
        end
    end

    assign o_i_sym     = r_i;
    assign o_q_sym     = r_q;
    assign o_sym_valid = r_valid;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_underrun  = r_under;
endmodule
